// File: rtl/link_pkg.sv
// Shared serial-link definitions: framing bytes, command codes, receiver state enum.
// The framing constants are common to the packet transmitter and command_receiver.
package link_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'd100;
    localparam logic [7:0] FTR_BYTE    = 8'd52;

    localparam logic [7:0] CMD_PING    = 8'h70;
    localparam logic [7:0] CMD_ENABLE  = 8'h65;
    localparam logic [7:0] CMD_DISABLE = 8'h78;
    localparam logic [7:0] CMD_NONCE   = 8'h6E;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_CMD,
        RX_PAYLOAD,
        RX_FOOTER
    } rx_state_t;

    typedef enum logic [1:0] {
        OP_PING,
        OP_ENABLE,
        OP_DISABLE,
        OP_NONCE
    } rx_op_t;

    function automatic logic is_cmd_byte(input logic [7:0] b);
        return (b == CMD_PING) || (b == CMD_ENABLE) ||
               (b == CMD_DISABLE) || (b == CMD_NONCE);
    endfunction

    function automatic rx_op_t decode_op(input logic [7:0] b);
        rx_op_t op;
        case (b)
            CMD_ENABLE:  op = OP_ENABLE;
            CMD_DISABLE: op = OP_DISABLE;
            CMD_NONCE:   op = OP_NONCE;
            default:     op = OP_PING;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: reloads on clear, counts down while enabled, flags terminal count.
// Only instantiated when COMMAND_RECEIVER_RX_TIMEOUT_EN is defined.
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] RELOAD = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (clear) begin
            count <= RELOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Terminal count reached after TIMEOUT_CYCLES-1 enabled cycles since the last clear.
    assign tc = enable && (count == '0);

endmodule

// File: rtl/command_receiver.sv
// Host command frame decoder: 'd' <cmd> [payload] '4' -> ping, chip enable, nonce seed.
// Optional inter-byte timeout under COMMAND_RECEIVER_RX_TIMEOUT_EN.
//
// state      | meaning
// RX_IDLE    | hunting for header byte, other bytes dropped silently
// RX_CMD     | header seen, next byte is the command
// RX_PAYLOAD | collecting nonce seed bytes into the shadow register
// RX_FOOTER  | expecting footer; commit on match, error otherwise
module command_receiver
    import link_pkg::*;
#(
    parameter int NONCE_BYTES    = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     rx_new_i,
    input  logic [7:0]               rx_data_i,
    output logic                     ping_req_o,
    output logic                     chip_enable_o,
    output logic [8*NONCE_BYTES-1:0] nonce_seed_o,
    output logic                     nonce_load_o,
    output logic                     frame_error_o,
    output logic                     busy_o
);

    localparam int W     = 8 * NONCE_BYTES;
    localparam int CNT_W = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
    localparam logic [CNT_W-1:0] NONCE_LAST = CNT_W'(NONCE_BYTES - 1);

    rx_state_t        state, state_next;
    rx_op_t           op, op_next;
    logic [CNT_W-1:0] byte_cnt, cnt_next;
    logic [W-1:0]     shift_reg, shift_next;
    logic [W-1:0]     seed_next;
    logic             chip_next, ping_next, load_next, ferr_next, busy_next;
    logic             timeout;

`ifdef COMMAND_RECEIVER_RX_TIMEOUT_EN
    logic gap_tc;

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (rx_new_i || (state == RX_IDLE)),
        .enable  (state != RX_IDLE),
        .tc      (gap_tc)
    );

    // A byte arriving on the terminal-count cycle takes priority over the timeout.
    assign timeout = gap_tc && !rx_new_i;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_next = state;
        op_next    = op;
        cnt_next   = byte_cnt;
        shift_next = shift_reg;
        seed_next  = nonce_seed_o;
        chip_next  = chip_enable_o;
        ping_next  = 1'b0;
        load_next  = 1'b0;
        ferr_next  = 1'b0;

        if (timeout) begin
            state_next = RX_IDLE;
            ferr_next  = 1'b1;
        end else if (rx_new_i) begin
            case (state)
                RX_IDLE: begin
                    if (rx_data_i == HDR_BYTE) state_next = RX_CMD;
                end
                RX_CMD: begin
                    if (is_cmd_byte(rx_data_i)) begin
                        op_next = decode_op(rx_data_i);
                        if (rx_data_i == CMD_NONCE) begin
                            cnt_next   = NONCE_LAST;
                            shift_next = '0;
                            state_next = RX_PAYLOAD;
                        end else begin
                            state_next = RX_FOOTER;
                        end
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = RX_IDLE;
                    end
                end
                RX_PAYLOAD: begin
                    // First payload byte ends up in the most significant position.
                    shift_next = W'({shift_reg, rx_data_i});
                    if (byte_cnt == '0) state_next = RX_FOOTER;
                    else                cnt_next   = byte_cnt - 1'b1;
                end
                RX_FOOTER: begin
                    state_next = RX_IDLE;
                    if (rx_data_i == FTR_BYTE) begin
                        case (op)
                            OP_PING:    ping_next = 1'b1;
                            OP_ENABLE:  chip_next = 1'b1;
                            OP_DISABLE: chip_next = 1'b0;
                            OP_NONCE: begin
                                seed_next = shift_reg;
                                load_next = 1'b1;
                            end
                            default:    ping_next = 1'b0;
                        endcase
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end

        busy_next = (state_next != RX_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= RX_IDLE;
            op            <= OP_PING;
            byte_cnt      <= '0;
            shift_reg     <= '0;
            nonce_seed_o  <= '0;
            chip_enable_o <= 1'b0;
            ping_req_o    <= 1'b0;
            nonce_load_o  <= 1'b0;
            frame_error_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state         <= state_next;
            op            <= op_next;
            byte_cnt      <= cnt_next;
            shift_reg     <= shift_next;
            nonce_seed_o  <= seed_next;
            chip_enable_o <= chip_next;
            ping_req_o    <= ping_next;
            nonce_load_o  <= load_next;
            frame_error_o <= ferr_next;
            busy_o        <= busy_next;
        end
    end

endmodule

// File: tb/tb_command_receiver.sv
// Directed bench for command_receiver; timeout scenario runs when
// COMMAND_RECEIVER_RX_TIMEOUT_EN is defined.
module tb_command_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_new = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        ping_req, chip_enable, nonce_load, frame_error, busy;
    logic [63:0] nonce_seed;

    int checks = 0;
    int errors = 0;
    int cnt_ping = 0, cnt_load = 0, cnt_ferr = 0;

    logic        last_ping, last_load, last_ferr, last_busy, last_chip;
    logic [63:0] last_seed;

    command_receiver #(
        .NONCE_BYTES    (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rx_new_i      (rx_new),
        .rx_data_i     (rx_data),
        .ping_req_o    (ping_req),
        .chip_enable_o (chip_enable),
        .nonce_seed_o  (nonce_seed),
        .nonce_load_o  (nonce_load),
        .frame_error_o (frame_error),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters and one-hot check on the three pulse outputs.
    always @(posedge clk) begin
        #2;
        cnt_ping += int'(ping_req);
        cnt_load += int'(nonce_load);
        cnt_ferr += int'(frame_error);
        if (ping_req || nonce_load || frame_error) begin
            checks++;
            if ((int'(ping_req) + int'(nonce_load) + int'(frame_error)) > 1) begin
                errors++;
                $display("FAIL pulse_onehot: ping=%0b load=%0b ferr=%0b, required at most one high",
                         ping_req, nonce_load, frame_error);
            end
        end
    end

    task automatic snap();
        last_ping = ping_req;
        last_load = nonce_load;
        last_ferr = frame_error;
        last_busy = busy;
        last_chip = chip_enable;
        last_seed = nonce_seed;
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        snap();
        rx_new  = 1'b1;
        rx_data = b;
    endtask

    task automatic idle();
        @(negedge clk);
        snap();
        rx_new = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ping_req !== 1'b0 || nonce_load !== 1'b0 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: ping=%b load=%b ferr=%b, required 0 0 0", ping_req, nonce_load, frame_error);
        end
        checks++;
        if (chip_enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_levels: chip=%b busy=%b, required 0 0", chip_enable, busy);
        end
        checks++;
        if (nonce_seed !== 64'h0) begin
            errors++;
            $display("FAIL reset_seed: got %h, required 0", nonce_seed);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ping();
        int p0 = cnt_ping, l0 = cnt_load, f0 = cnt_ferr;
        drive(8'd100);
        checks++;
        if (last_busy !== 1'b0) begin
            errors++; $display("FAIL ping_busy_before: got %b, required 0", last_busy);
        end
        drive(8'h70);
        checks++;
        if (last_busy !== 1'b1) begin
            errors++; $display("FAIL ping_busy_rise: got %b, required 1", last_busy);
        end
        drive(8'd52);
        checks++;
        if (last_ping !== 1'b0) begin
            errors++; $display("FAIL ping_early: got %b, required 0", last_ping);
        end
        idle();
        checks++;
        if (last_ping !== 1'b1 || last_busy !== 1'b0) begin
            errors++; $display("FAIL ping_pulse: ping=%b busy=%b, required 1 0", last_ping, last_busy);
        end
        idle();
        checks++;
        if (last_ping !== 1'b0) begin
            errors++; $display("FAIL ping_width: got %b, required 0", last_ping);
        end
        checks++;
        if (cnt_ping - p0 != 1 || cnt_load - l0 != 0 || cnt_ferr - f0 != 0) begin
            errors++;
            $display("FAIL ping_counts: ping=%0d load=%0d ferr=%0d, required 1 0 0",
                     cnt_ping - p0, cnt_load - l0, cnt_ferr - f0);
        end
    endtask

    task automatic test_enable_disable();
        int f0 = cnt_ferr;
        drive(8'd100); drive(8'h65); drive(8'd52);
        checks++;
        if (last_chip !== 1'b0) begin
            errors++; $display("FAIL en_before_commit: got %b, required 0", last_chip);
        end
        idle();
        checks++;
        if (last_chip !== 1'b1) begin
            errors++; $display("FAIL en_set: got %b, required 1", last_chip);
        end
        drive(8'd100); drive(8'h78); drive(8'd52); idle();
        checks++;
        if (last_chip !== 1'b0) begin
            errors++; $display("FAIL en_clear: got %b, required 0", last_chip);
        end
        idle();
        checks++;
        if (cnt_ferr - f0 != 0) begin
            errors++; $display("FAIL en_no_error: got %0d errors pulses, required 0", cnt_ferr - f0);
        end
    endtask

    task automatic test_nonce();
        int l0 = cnt_load;
        drive(8'd100); drive(8'h6E);
        for (int i = 1; i <= 8; i++) drive(8'(i));
        drive(8'd52);
        checks++;
        if (last_busy !== 1'b1 || last_seed !== 64'h0) begin
            errors++; $display("FAIL nonce_mid: busy=%b seed=%h, required 1 0", last_busy, last_seed);
        end
        idle();
        checks++;
        if (last_load !== 1'b1 || last_seed !== 64'h0102030405060708) begin
            errors++;
            $display("FAIL nonce_commit: load=%b seed=%h, required 1 0102030405060708", last_load, last_seed);
        end
        idle();
        checks++;
        if (last_load !== 1'b0 || cnt_load - l0 != 1) begin
            errors++; $display("FAIL nonce_single: load=%b count=%0d, required 0 1", last_load, cnt_load - l0);
        end
    endtask

    task automatic test_bad_footer();
        int l0 = cnt_load, f0 = cnt_ferr;
        drive(8'd100); drive(8'h6E);
        for (int i = 0; i < 8; i++) drive(8'hA0 + 8'(i));
        drive(8'h00);
        idle();
        checks++;
        if (last_ferr !== 1'b1 || last_busy !== 1'b0) begin
            errors++; $display("FAIL badftr_error: ferr=%b busy=%b, required 1 0", last_ferr, last_busy);
        end
        idle();
        checks++;
        if (last_seed !== 64'h0102030405060708 || cnt_load - l0 != 0 || cnt_ferr - f0 != 1) begin
            errors++;
            $display("FAIL badftr_keep: seed=%h loads=%0d ferrs=%0d, required 0102030405060708 0 1",
                     last_seed, cnt_load - l0, cnt_ferr - f0);
        end
    endtask

    task automatic test_bad_cmd();
        int p0 = cnt_ping, f0 = cnt_ferr;
        drive(8'd100); drive(8'h71);
        drive(8'd100);
        checks++;
        if (last_ferr !== 1'b1 || last_busy !== 1'b0) begin
            errors++; $display("FAIL badcmd_error: ferr=%b busy=%b, required 1 0", last_ferr, last_busy);
        end
        drive(8'h70); drive(8'd52); idle();
        checks++;
        if (last_ping !== 1'b1) begin
            errors++; $display("FAIL badcmd_recover: ping=%b, required 1", last_ping);
        end
        idle();
        checks++;
        if (cnt_ping - p0 != 1 || cnt_ferr - f0 != 1) begin
            errors++; $display("FAIL badcmd_counts: ping=%0d ferr=%0d, required 1 1", cnt_ping - p0, cnt_ferr - f0);
        end
    endtask

    task automatic test_header_in_frame();
        int p0 = cnt_ping, f0 = cnt_ferr;
        drive(8'h55); drive(8'd52);
        drive(8'd100); drive(8'd100);
        drive(8'd100); drive(8'h70); drive(8'd100);
        idle(); idle();
        checks++;
        if (cnt_ping - p0 != 0 || cnt_ferr - f0 != 2 || last_busy !== 1'b0) begin
            errors++;
            $display("FAIL hdr_as_data: ping=%0d ferr=%0d busy=%b, required 0 2 0",
                     cnt_ping - p0, cnt_ferr - f0, last_busy);
        end
    endtask

    task automatic test_back_to_back();
        int f0 = cnt_ferr;
        drive(8'd100); drive(8'h65); drive(8'd52);
        drive(8'd100);
        checks++;
        if (last_chip !== 1'b1) begin
            errors++; $display("FAIL b2b_enable: got %b, required 1", last_chip);
        end
        drive(8'h78);
        checks++;
        if (last_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy: got %b, required 1", last_busy);
        end
        drive(8'd52); idle();
        checks++;
        if (last_chip !== 1'b0 || cnt_ferr - f0 != 0) begin
            errors++; $display("FAIL b2b_disable: chip=%b ferr=%0d, required 0 0", last_chip, cnt_ferr - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0, l0, f0;
        drive(8'd100); drive(8'h65);
        @(negedge clk);
        rx_new = 1'b0;
        rst_n  = 1'b0;
        p0 = cnt_ping; l0 = cnt_load; f0 = cnt_ferr;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || chip_enable !== 1'b0) begin
            errors++; $display("FAIL midrst_state: busy=%b chip=%b, required 0 0", busy, chip_enable);
        end
        drive(8'd52); idle(); idle();
        checks++;
        if (last_chip !== 1'b0 || cnt_ping - p0 != 0 || cnt_load - l0 != 0 || cnt_ferr - f0 != 0) begin
            errors++;
            $display("FAIL midrst_nocommit: chip=%b ping=%0d load=%0d ferr=%0d, required 0 0 0 0",
                     last_chip, cnt_ping - p0, cnt_load - l0, cnt_ferr - f0);
        end
        drive(8'd100); drive(8'h70); drive(8'd52); idle();
        checks++;
        if (last_ping !== 1'b1) begin
            errors++; $display("FAIL midrst_recover: ping=%b, required 1", last_ping);
        end
    endtask

`ifdef COMMAND_RECEIVER_RX_TIMEOUT_EN
    task automatic test_timeout();
        int f0 = cnt_ferr, l0 = cnt_load;
        drive(8'd100); drive(8'h6E);
        drive(8'h01); drive(8'h02); drive(8'h03);
        repeat (20) idle();
        checks++;
        if (cnt_ferr - f0 != 1 || last_busy !== 1'b0 || cnt_load - l0 != 0) begin
            errors++;
            $display("FAIL timeout_fire: ferr=%0d busy=%b load=%0d, required 1 0 0",
                     cnt_ferr - f0, last_busy, cnt_load - l0);
        end
        drive(8'd100); drive(8'h6E);
        for (int i = 0; i < 8; i++) drive(8'h11 + 8'(i));
        drive(8'd52); idle(); idle();
        checks++;
        if (last_seed !== 64'h1112131415161718 || cnt_load - l0 != 1 || cnt_ferr - f0 != 1) begin
            errors++;
            $display("FAIL timeout_recover: seed=%h load=%0d ferr=%0d, required 1112131415161718 1 1",
                     last_seed, cnt_load - l0, cnt_ferr - f0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ping();
        test_enable_disable();
        test_nonce();
        test_bad_footer();
        test_bad_cmd();
        test_header_in_frame();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef COMMAND_RECEIVER_RX_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/command_receiver.md
# command_receiver

Host-to-FPGA command decoder on the serial link; the mirror of the packet transmitter. It consumes bytes from the UART receiver and frames them as header `100` ('d'), command byte, optional payload, footer `52` ('4'). Validated frames are decoded into a ping request, a chip enable level and a nonce seed load. Outputs feed the ping/nonce "waiting" flags and the hashing core's control registers.

## Interface
Parameters:
- `NONCE_BYTES`, default 8: number of payload bytes in a nonce-seed frame; seed width is 8*NONCE_BYTES.
- `TIMEOUT_CYCLES`, default 1000000: maximum gap between bytes inside a frame, in clk_i cycles. Used only with RX_TIMEOUT_EN.

Ports:
- `clk_i`  in  1  sole clock; all logic on its rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `rx_new_i`  in  1  one-cycle strobe; rx_data_i is valid this cycle.
- `rx_data_i`  in  8  received byte.
- `ping_req_o`  out  1  one-cycle pulse on a valid ping frame.
- `chip_enable_o`  out  1  level; set by an enable frame, cleared by a disable frame.
- `nonce_seed_o`  out  8*NONCE_BYTES  last committed seed.
- `nonce_load_o`  out  1  one-cycle pulse; nonce_seed_o was updated this cycle.
- `frame_error_o`  out  1  one-cycle pulse on an aborted frame.
- `busy_o`  out  1  high while state != IDLE.

## Operation
- States: IDLE, CMD, PAYLOAD, FOOTER.
- IDLE: on rx_new_i with data 100, go to CMD. Any other byte is dropped silently, with no error.
- CMD: on rx_new_i, decode the byte:
  - 'p' (0x70), 'e' (0x65) or 'x' (0x78): latch the command and go to FOOTER.
  - 'n' (0x6E): latch the command, load the byte counter with NONCE_BYTES-1, clear the shadow register and go to PAYLOAD.
  - Any other byte: pulse frame_error_o and go to IDLE.
- PAYLOAD: on each rx_new_i, shift_reg <= {shift_reg[W-9:0], rx_data_i}. The first byte received ends up most significant. When the counter is 0, go to FOOTER; otherwise decrement the counter.
- FOOTER: on rx_new_i with data 52, commit the latched command and go to IDLE. On any other byte, pulse frame_error_o, go to IDLE and commit nothing.
- Commit actions:
  - 'p': pulse ping_req_o.
  - 'e': chip_enable_o <= 1.
  - 'x': chip_enable_o <= 0.
  - 'n': nonce_seed_o <= shadow register, and pulse nonce_load_o.
- Nothing is committed except on a valid footer. A partially received seed never reaches nonce_seed_o.
- A header byte (100) received in CMD, PAYLOAD or FOOTER is treated as ordinary data: a bad command, a payload byte, or a bad footer respectively. There is no resynchronisation inside a frame.

## Timing
- Reset values: state IDLE; ping_req_o, nonce_load_o, frame_error_o, chip_enable_o and busy_o are 0; nonce_seed_o is all zeros; counters are 0.
- Reset asserted mid-frame returns to IDLE next edge, with no pulses and no commit.
- All outputs are registered. Commit and error pulses assert the cycle after the rx_new_i that causes them, and last exactly one cycle.
- busy_o rises the cycle after the header strobe and falls the cycle after the terminating byte.
- Back-to-back rx_new_i on consecutive cycles must be accepted. A header arriving the cycle after a footer starts a new frame.
- At most one of ping_req_o, nonce_load_o and frame_error_o is high in any cycle.

## Configuration
- `COMMAND_RECEIVER_RX_TIMEOUT_EN` defined:
  - An inter-byte counter clears on every rx_new_i and on entry to IDLE, and counts while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe, pulse frame_error_o next cycle, return to IDLE, commit nothing.
  - If rx_new_i coincides with the terminal count, the byte wins and the timeout does not fire.
- Undefined: no counter; the block waits indefinitely in any state.

## Structure
- Shared package `link_pkg` holds:
  - byte constants HDR_BYTE=100 and FTR_BYTE=52, also used by the transmitter;
  - command codes CMD_PING, CMD_ENABLE, CMD_DISABLE, CMD_NONCE;
  - the receiver state enum.
- One sub-module: `rx_gap_timer`, the inter-byte timeout counter with clear/enable inputs and a terminal-count output. Instantiate it only under the macro.

## Test plan
- Send 100, 'p', 52 -> one ping_req_o pulse one cycle after the footer strobe; no other pulses.
- Send 100, 'e', 52, then 100, 'x', 52 -> chip_enable_o goes 0→1→0; frame_error_o never pulses.
- Send 100, 'n', 0x01..0x08, 52 (NONCE_BYTES=8) -> nonce_seed_o = 0x0102030405060708 with a single nonce_load_o pulse.
- Send 100, 'n', 8 bytes, then 0x00 as footer -> frame_error_o pulses; nonce_seed_o keeps its prior value; busy_o drops.
- Send 100, 'q' -> frame_error_o pulses; then 100, 'p', 52 on consecutive cycles -> ping accepted.
- With the macro, TIMEOUT_CYCLES=16: send 100, 'n', 3 bytes, then idle 20 cycles -> frame_error_o pulses once; a following valid nonce frame loads correctly.
